// File: rtl/fnd_bcd_scan_ctrl.sv
// Captures a binary count, converts it to four BCD digits with a sequential
// double-dabble engine, and scans them onto a 4-digit common-anode FND.
module fnd_bcd_scan_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int W_COUNT  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_COUNT-1:0] i_count,
  input  logic               i_valid,
  input  logic               i_blank_lz,
  output logic               o_busy,
  output logic [3:0]         fnd_com,
  output logic [7:0]         fnd_data
);

  localparam int DIV = CLK_FREQ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(W_COUNT + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(W_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W_COUNT-1:0] bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [IW-1:0]      iter_q, iter_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic [W_COUNT-1:0] pend_val_q, pend_val_d;
  logic [15:0]        disp_q, disp_d;
  logic               disp_err_q, disp_err_d;
  logic               busy_q, busy_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         com_q, com_d;
  logic [7:0]         seg_q, seg_d;

  logic               req_valid_s;
  logic [W_COUNT-1:0] req_val_s;
  logic               req_big_s;
  logic [15:0]        bcd_adj_s;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (b[k*4 +: 4] >= 4'd5) begin
        r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
      end else begin
        r[k*4 +: 4] = b[k*4 +: 4];
      end
    end
    return r;
  endfunction

  // A strobe arriving in the same cycle as a start opportunity beats the stored one.
  assign req_valid_s = i_valid | pend_q;
  assign req_val_s   = i_valid ? i_count : pend_val_q;
  assign req_big_s   = 32'(req_val_s) > 32'd9999;
  assign bcd_adj_s   = dabble_adjust(bcd_q);

  // Conversion FSM, pending request and display commit.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    err_d      = err_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    disp_err_d = disp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_s) begin
          pend_d  = 1'b0;
          bin_d   = req_val_s;
          bcd_d   = 16'd0;
          iter_d  = '0;
          err_d   = req_big_s;
          state_d = req_big_s ? ST_DONE : ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bcd_d  = {bcd_adj_s[14:0], bin_q[W_COUNT-1]};
        bin_d  = bin_q << 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONV;
        end
        if (i_valid) begin
          pend_d     = 1'b1;
          pend_val_d = i_count;
        end else begin
          pend_d     = pend_q;
        end
      end
      ST_DONE: begin
        if (err_q) begin
          disp_err_d = 1'b1;
        end else begin
          disp_d     = bcd_q;
          disp_err_d = 1'b0;
        end
        if (req_valid_s) begin
          pend_d  = 1'b0;
          bin_d   = req_val_s;
          bcd_d   = 16'd0;
          iter_d  = '0;
          err_d   = req_big_s;
          state_d = req_big_s ? ST_DONE : ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Digit scan: advance on prescaler wrap and latch the enable and segment pair together.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    com_d   = com_q;
    seg_d   = seg_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      com_d   = ~(4'b0001 << idx_d);
      if (disp_err_q) begin
        seg_d = 8'hBF;
      end else begin
        case (idx_d)
          2'd1:    seg_d = (i_blank_lz && disp_q[15:4] == 12'd0) ? 8'hFF : seg7(disp_q[7:4]);
          2'd2:    seg_d = (i_blank_lz && disp_q[15:8] == 8'd0) ? 8'hFF : seg7(disp_q[11:8]);
          2'd3:    seg_d = (i_blank_lz && disp_q[15:12] == 4'd0) ? 8'hFF : seg7(disp_q[15:12]);
          default: seg_d = seg7(disp_q[3:0]);
        endcase
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= 16'd0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= 16'd0;
      disp_err_q <= 1'b0;
      busy_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= 2'd0;
      com_q      <= 4'b1110;
      seg_q      <= 8'hC0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
      disp_err_q <= disp_err_d;
      busy_q     <= busy_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      com_q      <= com_d;
      seg_q      <= seg_d;
    end
  end

  assign o_busy   = busy_q;
  assign fnd_com  = com_q;
  assign fnd_data = seg_q;

endmodule

// File: tb/tb_fnd_bcd_scan_ctrl.sv
// Randomized self-checking bench for fnd_bcd_scan_ctrl; expected digits come
// from decimal arithmetic on the requested value.
module tb_fnd_bcd_scan_ctrl;
  localparam int CF  = 1000;
  localparam int SH  = 100;
  localparam int W   = 14;
  localparam int DIV = CF / SH;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] i_count = '0;
  logic         i_valid = 1'b0;
  logic         i_blank_lz = 1'b0;
  logic         o_busy;
  logic [3:0]   fnd_com;
  logic [7:0]   fnd_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_bcd_scan_ctrl #(.CLK_FREQ(CF), .SCAN_HZ(SH), .W_COUNT(W)) dut (
    .clk(clk), .rst(rst), .i_count(i_count), .i_valid(i_valid),
    .i_blank_lz(i_blank_lz), .o_busy(o_busy), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(input int val, input bit err, input bit blank, input int k);
    int p;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    if (err) return 8'hBF;
    if (blank && k > 0 && val < p) return 8'hFF;
    return segtab[(val / p) % 10];
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check_display(input int val, input bit err, input string name);
    int seen;
    int k;
    seen = 0;
    repeat (DIV + 2) @(negedge clk);
    for (int i = 0; i < 4 * DIV; i++) begin
      k = com_idx(fnd_com);
      checks++;
      if (k < 0) begin
        failures++;
        $display("FAIL %s_com: got %b, required one digit enabled", name, fnd_com);
      end else begin
        seen |= (1 << k);
        checks++;
        if (fnd_data !== exp_seg(val, err, i_blank_lz, k)) begin
          failures++;
          $display("FAIL %s_digit%0d: got %h, required %h", name, k, fnd_data,
                   exp_seg(val, err, i_blank_lz, k));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (seen != 15) begin
      failures++;
      $display("FAIL %s_scan: digits seen mask %b, required 1111", name, seen[3:0]);
    end
  endtask

  task automatic strobe_count(input int v, output int busy_cycles);
    @(negedge clk);
    i_count = W'(v);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    busy_cycles = 0;
    for (int j = 0; j < 40; j++) begin
      if (o_busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic convert_and_check(input int v, input string name);
    int bc;
    int exp_bc;
    bit err;
    err = (v > 9999);
    exp_bc = err ? 1 : 15;
    strobe_count(v, bc);
    checks++;
    if (bc != exp_bc) begin
      failures++;
      $display("FAIL %s_busy: got %0d cycles, required %0d", name, bc, exp_bc);
    end
    check_display(v, err, name);
  endtask

  task automatic test_reset();
    logic [3:0] ec;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
      failures++;
      $display("FAIL reset_hold: got busy=%b com=%b data=%h, required 0 1110 c0",
               o_busy, fnd_com, fnd_data);
    end
    rst = 1'b1;
    for (int i = 0; i < 4 * DIV; i++) begin
      ec = ~(4'b0001 << ((i / DIV) % 4));
      checks++;
      if (fnd_com !== ec || fnd_data !== 8'hC0 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_scan@%0d: got com=%b data=%h busy=%b, required com=%b data=c0 busy=0",
                 i, fnd_com, fnd_data, o_busy, ec);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boundaries();
    convert_and_check(9999, "max");
    i_blank_lz = 1'b1;
    convert_and_check(0, "zero_blank");
    i_blank_lz = 1'b0;
    convert_and_check(10000, "overrange");
  endtask

  task automatic test_back_to_back();
    int total;
    int window;
    int k;
    total = 0;
    window = 0;
    @(negedge clk);
    i_count = W'(42);
    i_valid = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (o_busy) begin
        total++;
        if (j < 30) window++;
      end
      if (j == 27) begin
        k = com_idx(fnd_com);
        checks++;
        if (k < 0 || fnd_data !== exp_seg(42, 1'b0, 1'b0, k)) begin
          failures++;
          $display("FAIL b2b_first: got com=%b data=%h, required digit of 0042", fnd_com, fnd_data);
        end
      end
      case (j)
        0: i_valid = 1'b0;
        3: begin i_count = W'(100); i_valid = 1'b1; end
        4: i_valid = 1'b0;
        6: begin i_count = W'(777); i_valid = 1'b1; end
        7: i_valid = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if (total != 30 || window != 30) begin
      failures++;
      $display("FAIL b2b_busy: got total=%0d contiguous=%0d, required 30 and 30", total, window);
    end
    check_display(777, 1'b0, "b2b_final");
  endtask

  task automatic test_blank();
    i_blank_lz = 1'b1;
    convert_and_check(705, "blank_on");
    i_blank_lz = 1'b0;
    check_display(705, 1'b0, "blank_off");
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 10; n++) begin
      v = $urandom_range(0, 9999);
      if ($urandom_range(0, 3) == 0) v = $urandom_range(10000, 16383);
      i_blank_lz = 1'($urandom_range(0, 1));
      convert_and_check(v, $sformatf("rand%0d_%0d", n, v));
    end
    i_blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_count = W'(5678);
    i_valid = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
      failures++;
      $display("FAIL midreset: got busy=%b com=%b data=%h, required 0 1110 c0",
               o_busy, fnd_com, fnd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    check_display(0, 1'b0, "after_reset");
    convert_and_check(321, "post_reset");
  endtask

  initial begin
    test_reset();
    convert_and_check(1234, "conv1234");
    test_boundaries();
    test_back_to_back();
    test_blank();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_bcd_scan_ctrl.md
Name: fnd_bcd_scan_ctrl

Overview:
Display-side consumer of the 0–9999 counter value. Captures a 14-bit binary count on a valid strobe and converts it to four BCD digits with a sequential double-dabble engine. Time-multiplexes the digits onto a 4-digit common-anode FND with active-low digit enables and active-low segments. Sits between counter_top's count output and the board FND pins.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
SCAN_HZ, 1000, per-digit scan rate; digit period = CLK_FREQ/SCAN_HZ cycles
W_COUNT, 14, width of the binary count input

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
i_count  input  W_COUNT  binary count value to display
i_valid  input  1  single-cycle strobe; i_count is sampled on the same edge
i_blank_lz  input  1  1 = blank leading zeros
o_busy  output  1  conversion in progress
fnd_com  output  4  digit enables, active-low; bit0 = ones digit
fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, o_busy=0, pending flag cleared, displayed digits=0000, error flag=0, scan index=0, prescaler=0. Outputs: fnd_com=4'b1110, fnd_data=8'hC0.
- FSM states: IDLE, CONV, DONE.
- IDLE, i_valid=1: latch i_count.
  - Value <= 9999: go to CONV.
  - Value > 9999: set error flag and go directly to DONE.
- CONV: 14 iterations, one per clock. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd,bin} left by 1. After the 14th iteration go to DONE.
- DONE: one cycle. Commit the BCD result (or the error flag) to the display registers, then go to IDLE, or to CONV/DONE if a request is pending.
- o_busy=1 in CONV and DONE, 0 in IDLE.
- Latency: i_valid at edge N → o_busy high from N+1. Display registers update at edge N+15 for in-range values and at edge N+1 for out-of-range values.
- i_valid while busy: stored in a one-deep pending register. A later i_valid overwrites it (latest wins). The pending value starts at the DONE→next transition with no IDLE cycle in between.
- Display registers hold the last committed value until the next DONE; the display never shows a partial conversion.
- Scan prescaler counts 0 .. CLK_FREQ/SCAN_HZ-1. At terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
- fnd_com per index: 1110, 1101, 1011, 0111. Exactly one digit is enabled at any time, including during reset.
- Segment codes for 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. dp is always off (bit7=1).
- Error flag set: all four digits show dash 8'hBF, regardless of i_blank_lz.
- Leading-zero blanking (i_blank_lz=1): digits above the most significant nonzero digit output 8'hFF. The ones digit is never blanked. i_blank_lz is combinational on the output path and takes effect on the next scanned digit.
- fnd_com and fnd_data are registered; they change together on the prescaler wrap edge.
- rst asserted mid-conversion: conversion and pending request are aborted and the display returns to 0000.

Test Plan:
(Bench uses CLK_FREQ=1000, SCAN_HZ=100, giving a 10-cycle digit period.)
1. Reset release, no stimulus → fnd_com=1110, fnd_data=C0. Over 40 cycles fnd_com cycles 1110/1101/1011/0111 with fnd_data=C0 on each digit; o_busy=0.
2. i_valid with i_count=1234 → o_busy high for exactly 15 cycles. Afterwards the scanned digits read ones=99(4), tens=B0(3), hundreds=A4(2), thousands=F9(1).
3. Boundaries: i_count=9999 → all digits 90. i_count=0 with i_blank_lz=1 → ones=C0, other three digits FF. i_count=10000 → all digits BF, o_busy high for 1 cycle.
4. Strobes 0042 then 0100 (while busy) then 0777 (while still busy) → display shows 0042, then 0777. 0100 is never displayed. o_busy stays high continuously across both conversions (30 cycles).
5. i_blank_lz=1 with value 0705 → digits 0x92, C0, F8, FF. Toggling i_blank_lz to 0 → thousands digit shows C0.
6. rst pulsed low at cycle 7 of converting 5678 → immediately o_busy=0 and fnd_com=1110. After release the display shows 0000, and a new strobe of 0321 converts normally.
